// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor: one full-subtractor cell plus a borrow
// flip-flop computes d = a - b over WIDTH cycles, with valid/ready on both sides.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] d_o,
  output logic             borrow_o,
  output logic             ovf_o
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             br_q;
  logic [CNT_W-1:0] cnt_q;
  logic             diff_bit;
  logic             br_next;
  logic             last_bit;
  logic             in_ready_d;
  logic             out_valid_d;

  // Full-subtractor cell on the current LSBs of the operand shift registers
  always_comb begin
    diff_bit = a_q[0] ^ b_q[0] ^ br_q;
    br_next  = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
    last_bit = (cnt_q == LAST_BIT);
  end

  // State register; handshake flags are registered alongside the state
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      in_ready_o  <= 1'b1;
      out_valid_o <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_o  <= in_ready_d;
      out_valid_o <= out_valid_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid_i)  state_d = BUSY;
      BUSY:    if (last_bit)    state_d = DONE;
      DONE:    if (out_ready_i) state_d = IDLE;
      default:                  state_d = IDLE;
    endcase
  end

  // Handshake flags decoded from the upcoming state so they land with it
  always_comb begin
    in_ready_d  = 1'b0;
    out_valid_d = 1'b0;
    case (state_d)
      IDLE:    in_ready_d  = 1'b1;
      DONE:    out_valid_d = 1'b1;
      default: ;
    endcase
  end

  // Datapath: capture on accept, one bit per cycle while busy, hold in DONE
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_q      <= '0;
      b_q      <= '0;
      br_q     <= 1'b0;
      cnt_q    <= '0;
      d_o      <= '0;
      borrow_o <= 1'b0;
      ovf_o    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid_i) begin
            a_q   <= a_i;
            b_q   <= b_i;
            br_q  <= 1'b0;
            cnt_q <= '0;
          end
        end
        BUSY: begin
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          d_o   <= {diff_bit, d_o[WIDTH-1:1]};
          br_q  <= br_next;
          cnt_q <= cnt_q + CNT_W'(1);
          // Signed overflow: borrow into the MSB differs from borrow out of it
          if (last_bit) begin
            borrow_o <= br_next;
            ovf_o    <= br_q ^ br_next;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
